// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the IF/ID stage and the decoder: field positions,
// the bubble instruction, opcode/funct encodings and the field-split helper.
package mips_pkg;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int JADDR_LSB  = 0;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_JR   = 6'h08,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_SLT  = 6'h2a
  } funct_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [25:0] jaddr;
  } id_fields_t;

  function automatic id_fields_t split_instr(input logic [31:0] instr);
    id_fields_t f;
    f.opcode   = instr[OPCODE_LSB +: 6];
    f.rs       = instr[RS_LSB +: 5];
    f.rt       = instr[RT_LSB +: 5];
    f.rd       = instr[RD_LSB +: 5];
    f.shamt    = instr[SHAMT_LSB +: 5];
    f.funct    = instr[FUNCT_LSB +: 6];
    f.imm_sext = {{16{instr[IMM_LSB + 15]}}, instr[IMM_LSB +: 16]};
    f.jaddr    = instr[JADDR_LSB +: 26];
    return f;
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Valid/ready bus carrying {PC+4, instruction}; used on both the fetch and decode side.
interface if_id_stage_if #(
  parameter int PC_W = 32
);
  logic            valid;
  logic            ready;
  logic [PC_W-1:0] pc_plus4;
  logic [31:0]     instr;

  modport master (output valid, output pc_plus4, output instr, input ready);
  modport slave  (input valid, input pc_plus4, input instr, output ready);
endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer. in_ready depends only on registered state, so
// there is no combinational path from out_ready back to the producer.
module pipe_skid_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         push, pop;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign push      = in_valid & ~skid_valid_q;
  assign pop       = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Full: no push possible; a pop promotes the skid entry
      if (pop) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      case ({push, pop})
        2'b11: main_data_d = in_data;
        2'b01: main_valid_d = 1'b0;
        2'b10: begin
          skid_data_d  = in_data;
          skid_valid_d = 1'b1;
        end
        default: ;
      endcase
    end else if (push) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: skid-buffered fetch entries presented to decode with fields pre-split.
// Define IF_ID_PERF_CNT_EN to add saturating stall/flush performance counters.
module if_id_stage
  import mips_pkg::*;
#(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
`ifdef IF_ID_PERF_CNT_EN
  ,
  parameter int          CNT_W     = 32
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  if_id_stage_if.slave  fetch,
  if_id_stage_if.master dec,
  output logic [5:0]   id_opcode,
  output logic [4:0]   id_rs,
  output logic [4:0]   id_rt,
  output logic [4:0]   id_rd,
  output logic [4:0]   id_shamt,
  output logic [5:0]   id_funct,
  output logic [31:0]  id_imm_sext,
  output logic [25:0]  id_jaddr
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int W = PC_W + 32;

  logic [W-1:0] main_data;
  logic         id_valid;
  logic [31:0]  id_instr;
  id_fields_t   fields;

  pipe_skid_buf #(.W(W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (fetch.valid),
    .in_ready  (fetch.ready),
    .in_data   ({fetch.pc_plus4, fetch.instr}),
    .out_valid (id_valid),
    .out_ready (dec.ready),
    .out_data  (main_data)
  );

  // Stale data stays in the register after a pop or flush; decode must see a bubble
  assign id_instr     = id_valid ? main_data[31:0] : NOP_INSTR;
  assign dec.valid    = id_valid;
  assign dec.instr    = id_instr;
  assign dec.pc_plus4 = main_data[W-1:32];

  always_comb begin
    fields = split_instr(id_instr);
  end

  assign id_opcode   = fields.opcode;
  assign id_rs       = fields.rs;
  assign id_rt       = fields.rt;
  assign id_rd       = fields.rd;
  assign id_shamt    = fields.shamt;
  assign id_funct    = fields.funct;
  assign id_imm_sext = fields.imm_sext;
  assign id_jaddr    = fields.jaddr;

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (id_valid && !dec.ready && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && !(&flush_cnt_q))                  flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
